// File: rtl/ram_responder.sv
// Target end of the cache-to-RAM link: one read or write at a time, modelled access
// latency, response over a second valid/ready channel, owns the main-memory array.
module ram_responder #(
  parameter int AW     = 20,
  parameter int DW     = 32,
  parameter int RD_LAT = 4,
  parameter int WR_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [AW-1:0]    req_addr,
  input  logic [DW-1:0]    req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_wr,
  output logic [DW-1:0]    rsp_rdata,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] RD_L = 4'(RD_LAT);
  localparam logic [3:0] WR_L = 4'(WR_LAT);

  state_t          state, state_nx;
  logic [3:0]      cnt, lat;
  logic            l_wr;
  logic [AW-1:0]   l_addr;
  logic [DW-1:0]   l_wdata;
  logic            acc, entry, e_wr;
  logic [AW-1:0]   e_addr;
  logic [DW-1:0]   e_wdata;

  // Words are stored XORed with their address, so an all-zero power-up array
  // presents Mem[i] = i without any explicit initialisation pass.
  logic [DW-1:0]   mem [2**AW];

  function automatic logic [DW-1:0] scr(input logic [AW-1:0] a);
    return DW'(a);
  endfunction

  // Entry into RESP happens on the LAT-th edge counting the acceptance edge;
  // a latency of 1 enters RESP on the acceptance edge itself using the live request.
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    acc       = 1'b0;
    entry     = 1'b0;
    e_wr      = l_wr;
    e_addr    = l_addr;
    e_wdata   = l_wdata;
    lat       = req_wr ? WR_L : RD_L;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        acc       = req_valid;
        if (req_valid) begin
          e_wr    = req_wr;
          e_addr  = req_addr;
          e_wdata = req_wdata;
          if (lat == 4'd1) begin
            entry    = 1'b1;
            state_nx = RESP;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd2) begin
          entry    = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      l_wr      <= 1'b0;
      l_addr    <= '0;
      l_wdata   <= '0;
      rsp_valid <= 1'b0;
      rsp_wr    <= 1'b0;
      rsp_rdata <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        l_wr    <= req_wr;
        l_addr  <= req_addr;
        l_wdata <= req_wdata;
        cnt     <= lat;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (entry) begin
        rsp_valid <= 1'b1;
        rsp_wr    <= e_wr;
        rsp_rdata <= e_wr ? '0 : (mem[e_addr] ^ scr(e_addr));
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        if (rsp_wr) begin
          if (wr_count != '1) wr_count <= wr_count + CNT_W'(1);
        end else begin
          if (rd_count != '1) rd_count <= rd_count + CNT_W'(1);
        end
      end
    end
  end

  // A reset on the would-be commit edge drops the write.
  always_ff @(posedge clk) begin
    if (entry && e_wr && !rst) mem[e_addr] <= e_wdata ^ scr(e_addr);
  end

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: directed table, hand-written corner sequences and
// randomized traffic against an associative-array memory model.
module tb_ram_responder;
  localparam int RD_LAT = 4;
  localparam int WR_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_wr = 1'b0, rsp_ready = 1'b0;
  logic [19:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_wr;
  logic [31:0] rsp_rdata;
  logic [15:0] rd_count, wr_count;
  logic        req_ready2, rsp_valid2, rsp_wr2;
  logic [31:0] rsp_rdata2;
  logic [1:0]  rd_count2, wr_count2;

  always #5 clk = ~clk;

  ram_responder #(.AW(20), .DW(32), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata), .rd_count(rd_count), .wr_count(wr_count));

  ram_responder #(.AW(20), .DW(32), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_wr(rsp_wr2), .rsp_rdata(rsp_rdata2), .rd_count(rd_count2), .wr_count(wr_count2));

  int nvec = 0, nerr = 0;
  int rd_m = 0, wr_m = 0;
  logic [31:0] mem_m [logic [19:0]];

  typedef struct {
    bit          wr;
    logic [19:0] addr;
    logic [31:0] wdata;
    int          stall;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mdl_rd(input logic [19:0] a);
    return mem_m.exists(a) ? mem_m[a] : {12'd0, a};
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk_counts();
    chk("rd_count", rd_count, sat(rd_m, 65535));
    chk("wr_count", wr_count, sat(wr_m, 65535));
    chk("rd_count_sat", rd_count2, sat(rd_m, 3));
    chk("wr_count_sat", wr_count2, sat(wr_m, 3));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    rd_m = 0; wr_m = 0;
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_wr", rsp_wr, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk_counts();
  endtask

  task automatic txn(input bit wr, input logic [19:0] a, input logic [31:0] d,
                     input int stall, input logic [31:0] exp);
    int k;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; rsp_ready = 1'b0;
    chk("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 1;
    while (!rsp_valid && k < 20) begin
      chk("req_ready_wait", req_ready, 0);
      @(posedge clk); #1;
      k++;
    end
    chk(wr ? "wr_latency" : "rd_latency", k, wr ? WR_LAT : RD_LAT);
    if (wr) mem_m[a] = d;
    chk("rsp_wr", rsp_wr, wr);
    chk("rsp_rdata", rsp_rdata, exp);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("stall_valid", rsp_valid, 1);
      chk("stall_rdata", rsp_rdata, exp);
      chk("stall_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (wr) wr_m++; else rd_m++;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_req_ready", req_ready, 1);
    chk_counts();
  endtask

  vec_t tbl[4];

  initial begin
    tbl[0] = '{0, 20'd100,  32'd0,  0, 32'd100};
    tbl[1] = '{1, 20'd100,  32'd10, 0, 32'd0};
    tbl[2] = '{0, 20'd100,  32'd0,  0, 32'd10};
    tbl[3] = '{0, 20'd4396, 32'd0,  3, 32'd4396};

    repeat (3) @(posedge clk);
    do_reset();
    for (int i = 0; i < 4; i++) txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].stall, tbl[i].exp);

    // write dropped by reset during WAIT
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 20'd25; req_wdata = 32'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    do_reset();
    txn(0, 20'd25, 0, 0, 32'd25);

    // write already in RESP survives reset
    begin
      int k;
      @(negedge clk);
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 20'd26; req_wdata = 32'd9;
      @(posedge clk); #1;
      req_valid = 1'b0;
      k = 1;
      while (!rsp_valid && k < 20) begin @(posedge clk); #1; k++; end
      chk("resp_reached", rsp_valid, 1);
      mem_m[20'd26] = 32'd9;
      do_reset();
      txn(0, 20'd26, 0, 0, 32'd9);
    end

    // req_valid held continuously across three reads
    begin
      int nacc, nrsp, last;
      bit acc;
      nacc = 0; nrsp = 0; last = 0;
      @(negedge clk);
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 20'd1; rsp_ready = 1'b1;
      for (int c = 0; c < 60 && nrsp < 3; c++) begin
        if (rsp_valid) begin
          chk("stream_rdata", rsp_rdata, mdl_rd(20'(nrsp + 1)));
          nrsp++; rd_m++;
        end
        acc = req_valid && req_ready;
        if (acc) begin
          if (nacc > 0) chk("accept_spacing", c - last, RD_LAT + 1);
          last = c; nacc++;
        end
        @(posedge clk); #1;
        if (acc) begin
          if (nacc == 3) req_valid = 1'b0; else req_addr = 20'(nacc + 1);
        end
        @(negedge clk);
      end
      rsp_ready = 1'b0;
      chk("stream_accepts", nacc, 3);
      chk("stream_rsps", nrsp, 3);
      chk_counts();
    end

    // saturation of the narrow counters: 1,2,3,3,3
    do_reset();
    for (int i = 0; i < 5; i++) begin
      logic [19:0] a;
      a = 20'($urandom);
      txn(0, a, 0, 0, mdl_rd(a));
    end

    // randomized mix over a small address window so reads hit earlier writes
    for (int i = 0; i < 40; i++) begin
      bit wr;
      logic [19:0] a;
      logic [31:0] d;
      wr = 1'($urandom);
      a  = 20'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) a = 20'($urandom);
      d  = $urandom;
      txn(wr, a, d, $urandom_range(0, 2), wr ? 32'd0 : mdl_rd(a));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
